pim_mac_unit: RTL

- Next-generation PIM compute tile; multiplies two PIM_MATRIX_SIZE x PIM_MATRIX_SIZE chunks from the partition stage and hands the result to the result aggregator.
- Uses a time-multiplexed array of LANES multiply-accumulate units instead of a single-cycle full product.
- Adds valid/ready handshakes on input and output, plus an accumulate mode that sums successive chunk products into the held result for K-dimension tiling.
- Adds a completed-job counter.

---
 rtl/pim_mac_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pim_mac_unit.sv
// rtl/pim_mac_unit.sv - time-multiplexed NxN matrix multiply-accumulate tile
// LANES output elements advance one k-step per cycle; a job takes N*N*N/LANES cycles.
module pim_mac_unit #(
   parameter int ID              = 0,
   parameter int ELEM_WIDTH      = 32,
   parameter int PIM_MATRIX_SIZE = 8,
   parameter int LANES           = 8
) (
   input  logic                                                           clk,
   input  logic                                                           rst,
   input  logic                                                           in_valid,
   output logic                                                           in_ready,
   input  logic                                                           acc_en,
   input  logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] matrixA,
   input  logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] matrixB,
   output logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] result,
   output logic                                                           out_valid,
   input  logic                                                           out_ready,
   output logic                                                           busy,
   output logic [15:0]                                                    job_count
);

   localparam int N  = PIM_MATRIX_SIZE;
   localparam int NN = N * N;
   localparam int G  = NN / LANES;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int GW = (G > 1) ? $clog2(G) : 1;

   if ((NN % LANES) != 0) begin : g_bad_lanes
      $fatal(1, "pim_mac_unit: LANES (%0d) must divide N*N (%0d)", LANES, NN);
   end
   if (ID < 0) begin : g_bad_id
      $fatal(1, "pim_mac_unit: ID must be non-negative");
   end

   typedef logic [N-1:0][N-1:0][ELEM_WIDTH-1:0] mat_t;
   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [GW-1:0]   g_q, g_d;
   mat_t            a_q, a_d;
   mat_t            b_q, b_d;
   mat_t            result_q, result_d;
   logic [15:0]     job_count_q, job_count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         g_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         job_count_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         g_q         <= g_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         job_count_q <= job_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      g_d         = g_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      job_count_d = job_count_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = matrixA;
               b_d     = matrixB;
               k_d     = '0;
               g_d     = '0;
               state_d = COMPUTE;
               if (!acc_en) result_d = '0;
            end
         end
         COMPUTE: begin
            // Lane l of group g owns flat element g*LANES+l for all N k-steps.
            for (int l = 0; l < LANES; l++) begin
               automatic int            e_l = int'(g_q) * LANES + l;
               automatic logic [KW-1:0] ii  = KW'(e_l / N);
               automatic logic [KW-1:0] jj  = KW'(e_l % N);
               result_d[ii][jj] = result_q[ii][jj] + ELEM_WIDTH'(a_q[ii][k_q] * b_q[k_q][jj]);
            end
            if (k_q == KW'(N - 1)) begin
               k_d = '0;
               if (g_q == GW'(G - 1)) begin
                  g_d     = '0;
                  state_d = DONE;
               end else begin
                  g_d = g_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               job_count_d = job_count_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == COMPUTE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign job_count = job_count_q;

endmodule
